// File: rtl/vec_alu_engine.sv
// Windowed element-wise vector ALU engine: four host-accessible memories (A, B, OP, RESULT)
// and a three-stage issue/execute/writeback pipeline launched by a start/busy/done handshake.
module vec_alu_engine #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int OP_WIDTH   = 3
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  host_en,
   input  logic                  host_we,
   input  logic [1:0]            host_sel,
   input  logic [ADDR_WIDTH-1:0] host_addr,
   input  logic [DATA_WIDTH-1:0] host_wdata,
   output logic [DATA_WIDTH-1:0] host_rdata,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH-1:0] base_i,
   input  logic [ADDR_WIDTH:0]   len_i,
   output logic                  busy_o,
   output logic                  done_o
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int SH_W  = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   function automatic logic [DATA_WIDTH-1:0] alu_f(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b,
                                                   input logic [2:0]            op);
      logic [DATA_WIDTH-1:0] r;
      case (op)
         3'd0:    r = a + b;
         3'd1:    r = a - b;
         3'd2:    r = a & b;
         3'd3:    r = a | b;
         3'd4:    r = a ^ b;
         3'd5:    r = a << b[SH_W-1:0];
         3'd6:    r = a >> b[SH_W-1:0];
         3'd7:    r = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
         default: r = {DATA_WIDTH{1'b0}};
      endcase
      return r;
   endfunction

   logic [DATA_WIDTH-1:0] mem_a_r   [DEPTH];
   logic [DATA_WIDTH-1:0] mem_b_r   [DEPTH];
   logic [OP_WIDTH-1:0]   mem_op_r  [DEPTH];
   logic [DATA_WIDTH-1:0] mem_res_r [DEPTH];

   state_t                state_r;
   logic                  busy_r, done_r, drain_r;
   logic [ADDR_WIDTH-1:0] base_r;
   logic [ADDR_WIDTH:0]   len_r, cnt_r;
   logic [DATA_WIDTH-1:0] a_r, b_r, res_r, host_rdata_r;
   logic [OP_WIDTH-1:0]   op_r;
   logic                  s2_valid_r, s3_valid_r;
   logic [ADDR_WIDTH-1:0] s2_idx_r, s3_idx_r;

   logic                  issue_s, host_acc_s;
   logic [ADDR_WIDTH-1:0] rd_idx_s;
   logic [DATA_WIDTH-1:0] alu_s;

   assign busy_o     = busy_r;
   assign done_o     = done_r;
   assign host_rdata = host_rdata_r;

   // Issue address, ALU evaluation and host-access qualification.
   always_comb begin
      issue_s    = (state_r == ST_RUN);
      rd_idx_s   = base_r + cnt_r[ADDR_WIDTH-1:0];
      alu_s      = alu_f(a_r, b_r, op_r[2:0]);
      host_acc_s = host_en & ~busy_r;
   end

   // Memory arrays: host writes, engine writeback and synchronous engine reads; never reset.
   always_ff @(posedge CLK) begin
      if (host_acc_s && host_we) begin
         case (host_sel)
            2'd0:    mem_a_r[host_addr]   <= host_wdata;
            2'd1:    mem_b_r[host_addr]   <= host_wdata;
            2'd2:    mem_op_r[host_addr]  <= host_wdata[OP_WIDTH-1:0];
            default: mem_res_r[host_addr] <= host_wdata;
         endcase
      end
      // Host writes only reach RESULT while idle, so they never collide with writeback.
      if (s3_valid_r) begin
         mem_res_r[s3_idx_r] <= res_r;
      end
      a_r  <= mem_a_r[rd_idx_s];
      b_r  <= mem_b_r[rd_idx_s];
      op_r <= mem_op_r[rd_idx_s];
   end

   // Pipeline valids/indices, result register and host read data.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         s2_valid_r   <= 1'b0;
         s3_valid_r   <= 1'b0;
         s2_idx_r     <= {ADDR_WIDTH{1'b0}};
         s3_idx_r     <= {ADDR_WIDTH{1'b0}};
         res_r        <= {DATA_WIDTH{1'b0}};
         host_rdata_r <= {DATA_WIDTH{1'b0}};
      end else begin
         s2_valid_r <= issue_s;
         s2_idx_r   <= rd_idx_s;
         s3_valid_r <= s2_valid_r;
         s3_idx_r   <= s2_idx_r;
         res_r      <= alu_s;
         if (host_acc_s && !host_we) begin
            case (host_sel)
               2'd0:    host_rdata_r <= mem_a_r[host_addr];
               2'd1:    host_rdata_r <= mem_b_r[host_addr];
               2'd2:    host_rdata_r <= {{(DATA_WIDTH-OP_WIDTH){1'b0}}, mem_op_r[host_addr]};
               default: host_rdata_r <= mem_res_r[host_addr];
            endcase
         end
      end
   end

   // Run control FSM with registered busy/done.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         drain_r <= 1'b0;
         base_r  <= {ADDR_WIDTH{1'b0}};
         len_r   <= {(ADDR_WIDTH+1){1'b0}};
         cnt_r   <= {(ADDR_WIDTH+1){1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r  <= 1'b0;
               drain_r <= 1'b0;
               if (start_i) begin
                  base_r <= base_i;
                  len_r  <= len_i;
                  cnt_r  <= {(ADDR_WIDTH+1){1'b0}};
                  if (len_i == {(ADDR_WIDTH+1){1'b0}}) begin
                     state_r <= ST_DONE;
                     done_r  <= 1'b1;
                  end else begin
                     state_r <= ST_RUN;
                     busy_r  <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               cnt_r <= cnt_r + {{ADDR_WIDTH{1'b0}}, 1'b1};
               if (cnt_r == len_r - {{ADDR_WIDTH{1'b0}}, 1'b1}) begin
                  state_r <= ST_DRAIN;
                  drain_r <= 1'b0;
               end
            end
            ST_DRAIN: begin
               drain_r <= 1'b1;
               if (drain_r) begin
                  state_r <= ST_DONE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
               end
            end
            ST_DONE: begin
               done_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vec_alu_engine.sv
// Randomized bench for vec_alu_engine against an array-based reference model of the memories.
module tb_vec_alu_engine;

   logic        CLK, RST;
   logic        host_en, host_we;
   logic [1:0]  host_sel;
   logic [9:0]  host_addr;
   logic [31:0] host_wdata, host_rdata;
   logic        start_i;
   logic [9:0]  base_i;
   logic [10:0] len_i;
   logic        busy_o, done_o;

   vec_alu_engine dut (
      .CLK(CLK), .RST(RST),
      .host_en(host_en), .host_we(host_we), .host_sel(host_sel),
      .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
      .start_i(start_i), .base_i(base_i), .len_i(len_i),
      .busy_o(busy_o), .done_o(done_o)
   );

   logic [31:0] ma [1024];
   logic [31:0] mb [1024];
   logic [2:0]  mop [1024];
   logic [31:0] mres [1024];
   logic [31:0] op_exp [8] = '{32'hF000_0005, 32'hEFFF_FFFD, 32'h0000_0000, 32'hF000_0005,
                               32'hF000_0005, 32'h0000_0010, 32'h0F00_0000, 32'h0000_0000};
   int nvec = 0;
   int nerr = 0;

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return a << (b % 32);
         3'd6:    return a >> (b % 32);
         default: return (a < b) ? 32'd1 : 32'd0;
      endcase
   endfunction

   task automatic mwr(input int sel, input int addr, input logic [31:0] d);
      @(negedge CLK);
      host_en = 1'b1; host_we = 1'b1; host_sel = sel[1:0]; host_addr = addr[9:0]; host_wdata = d;
      @(negedge CLK);
      host_en = 1'b0; host_we = 1'b0;
      case (sel)
         0:       ma[addr]   = d;
         1:       mb[addr]   = d;
         2:       mop[addr]  = d[2:0];
         default: mres[addr] = d;
      endcase
   endtask

   task automatic host_rd(input int sel, input int addr, output logic [31:0] d);
      @(negedge CLK);
      host_en = 1'b1; host_we = 1'b0; host_sel = sel[1:0]; host_addr = addr[9:0];
      @(negedge CLK);
      host_en = 1'b0;
      d = host_rdata;
   endtask

   task automatic chk_res(input string tag, input int idx);
      logic [31:0] v;
      host_rd(3, idx, v);
      check_vec($sformatf("%s[%0d]", tag, idx), v, mres[idx]);
   endtask

   // Launch a run, watch busy/done each cycle; optionally poke the host port and start mid-run.
   task automatic run(input int base, input int len, input bit disturb);
      int done_cyc, busy_bad, idx;
      bit exp_b;
      done_cyc = -1;
      busy_bad = 0;
      @(negedge CLK);
      start_i = 1'b1; base_i = base[9:0]; len_i = len[10:0];
      for (int cyc = 1; cyc <= len + 8; cyc++) begin
         @(negedge CLK);
         if (cyc == 1) start_i = 1'b0;
         exp_b = (len != 0) && (cyc <= len + 2);
         if (busy_o !== exp_b) busy_bad++;
         if (done_o === 1'b1) begin
            done_cyc = cyc;
            break;
         end
         if (disturb && cyc == 5) begin
            host_en = 1'b1; host_we = 1'b1; host_sel = 2'd0; host_addr = 10'd202;
            host_wdata = 32'hDEAD_BEEF;
            start_i = 1'b1; base_i = 10'd0; len_i = 11'd3;
         end else if (disturb && cyc == 6) begin
            host_we = 1'b0; host_addr = 10'd201; start_i = 1'b0;
         end else if (disturb && cyc == 7) begin
            host_en = 1'b0;
         end
      end
      check_vec($sformatf("done_cycle len=%0d", len), done_cyc, (len == 0) ? 1 : len + 3);
      check_vec($sformatf("busy_window len=%0d", len), busy_bad, 0);
      @(negedge CLK);
      check_vec("done_pulse", {31'b0, done_o}, 32'd0);
      for (int k = 0; k < len; k++) begin
         idx = (base + k) % 1024;
         mres[idx] = ref_alu(ma[idx], mb[idx], mop[idx]);
      end
   endtask

   initial begin
      logic [31:0] v;
      int b, l, idx;
      RST = 1'b0; host_en = 1'b0; host_we = 1'b0; host_sel = 2'd0; host_addr = 10'd0;
      host_wdata = 32'd0; start_i = 1'b0; base_i = 10'd0; len_i = 11'd0;
      repeat (3) @(negedge CLK);
      check_vec("rst_busy", {31'b0, busy_o}, 32'd0);
      check_vec("rst_done", {31'b0, done_o}, 32'd0);
      check_vec("rst_rdata", host_rdata, 32'd0);
      @(negedge CLK);
      RST = 1'b1;

      for (int i = 0; i < 1024; i++) begin
         mwr(0, i, $urandom);
         mwr(1, i, $urandom);
         mwr(2, i, $urandom);
         mwr(3, i, $urandom);
      end
      host_rd(2, 5, v);
      check_vec("op_zext", v, {29'b0, mop[5]});

      for (int k = 0; k < 8; k++) begin
         mwr(0, k, k); mwr(1, k, 2 * k); mwr(2, k, 0);
      end
      run(0, 8, 1'b0);
      for (int k = 0; k < 8; k++) begin
         host_rd(3, k, v);
         check_vec($sformatf("add3k[%0d]", k), v, 3 * k);
      end

      for (int k = 0; k < 8; k++) begin
         mwr(0, 16 + k, 32'hF000_0001); mwr(1, 16 + k, 32'h0000_0004); mwr(2, 16 + k, k);
      end
      run(16, 8, 1'b0);
      for (int k = 0; k < 8; k++) begin
         host_rd(3, 16 + k, v);
         check_vec($sformatf("opcode%0d", k), v, op_exp[k]);
      end

      run(1020, 8, 1'b0);
      for (int j = 0; j < 13; j++) chk_res("wrap", (1016 + j) % 1024);

      repeat (6) begin
         b = $urandom_range(0, 1023);
         l = $urandom_range(1, 40);
         run(b, l, 1'b0);
         for (int j = -2; j <= l + 1; j++) chk_res("rand", (b + j + 1024) % 1024);
      end

      b = $urandom_range(0, 1023);
      run(b, 0, 1'b0);
      chk_res("len0", b);

      mwr(0, 200, 32'h2222_2222); mwr(0, 201, 32'h1111_1111); mwr(0, 202, 32'h3333_3333);
      host_rd(0, 200, v);
      run(300, 20, 1'b1);
      check_vec("rdata_hold", host_rdata, ma[200]);
      host_rd(0, 202, v);
      check_vec("busy_wr_ignored", v, ma[202]);
      for (int j = 0; j < 20; j++) chk_res("dist", 300 + j);

      b = $urandom_range(0, 1023);
      run(b, 1024, 1'b0);
      for (int i = 0; i < 1024; i++) chk_res("full", i);

      // Reset lands just after the third writeback commits.
      @(negedge CLK);
      start_i = 1'b1; base_i = 10'd100; len_i = 11'd8;
      @(posedge CLK);
      #1 start_i = 1'b0;
      repeat (5) @(posedge CLK);
      #1 RST = 1'b0;
      #1;
      check_vec("midrst_busy", {31'b0, busy_o}, 32'd0);
      check_vec("midrst_done", {31'b0, done_o}, 32'd0);
      check_vec("midrst_rdata", host_rdata, 32'd0);
      for (int k = 0; k < 3; k++) begin
         idx = 100 + k;
         mres[idx] = ref_alu(ma[idx], mb[idx], mop[idx]);
      end
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b1;
      for (int k = 0; k < 8; k++) chk_res("midrst", 100 + k);
      run(400, 5, 1'b0);
      for (int k = 0; k < 5; k++) chk_res("postrst", 400 + k);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/vec_alu_engine.md
# vec_alu_engine

Parametrised successor to the fixed 1024-entry vector processor. Streams element-wise ALU operations over a host-selected window of its operand, opcode and result memories. The block owns four synchronous-read memories (A, B, OP, RESULT) behind a single host port, and runs a pipelined issue/read/execute/writeback datapath started by a start/busy/done handshake. It sits under the system controller in place of the hard-wired 1024-element engine.

## Interface
- DATA_WIDTH, 32, operand/result width (power of two, ≥8)
- ADDR_WIDTH, 10, memory address width; depth = 2^ADDR_WIDTH
- OP_WIDTH, 3, opcode width (fixed semantics use 3 LSBs)
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  asynchronous, active-low reset
- host_en  in  1  host access strobe (ignored while busy_o=1)
- host_we  in  1  1=write, 0=read
- host_sel  in  2  0=A, 1=B, 2=OP, 3=RESULT
- host_addr  in  ADDR_WIDTH  host address
- host_wdata  in  DATA_WIDTH  write data; OP memory takes [OP_WIDTH-1:0]
- host_rdata  out  DATA_WIDTH  read data (OP reads zero-extended)
- start_i  in  1  run request, sampled in IDLE only
- base_i  in  ADDR_WIDTH  first element index, sampled with start
- len_i  in  ADDR_WIDTH+1  element count 0..2^ADDR_WIDTH, sampled with start
- busy_o  out  1  run in progress
- done_o  out  1  one-cycle completion pulse

## Operation
- States: IDLE, RUN, DRAIN, DONE. IDLE→RUN on start_i with len_i≠0; IDLE→DONE on start_i with len_i=0. RUN→DRAIN after len issues; DRAIN lasts 2 cycles; DONE lasts 1 cycle then IDLE.
- RUN issues one element per cycle: index i = (base + k) mod 2^ADDR_WIDTH, k=0..len-1; reads A[i], B[i], OP[i] in parallel.
- Stage 2 (one cycle after issue): memory data valid; ALU computes. Stage 3: result registered, written to RESULT[i] (index carried down pipeline).
- Opcodes: 0 ADD, 1 SUB (A−B), 2 AND, 3 OR, 4 XOR, 5 SLL A by B[log2(DATA_WIDTH)-1:0], 6 SRL (logical), 7 SLTU (1 if A<B unsigned else 0). All arithmetic mod 2^DATA_WIDTH, carries discarded. OP_WIDTH>3: upper bits ignored.
- Host port: read returns selected memory at host_addr one cycle after host_en; write commits on the host_en edge. While busy_o=1 host accesses are ignored, host_rdata holds its last value.
- start_i outside IDLE is ignored; start_i held high after DONE starts a new run from IDLE (level-sensitive, re-sampled).
- Window wrapping past top address continues from 0; len=2^ADDR_WIDTH processes every element exactly once.
- Memories are not reset; contents survive RST.

## Timing
- Reset values: busy_o=0, done_o=0, host_rdata=0, state IDLE, pipeline valids cleared.
- Cycle 0 = edge sampling start_i in IDLE. busy_o=1 from cycle 1 through end of DRAIN.
- Issue k at cycle 1+k; its RESULT write at cycle 3+k. Last write at cycle len+2; done_o=1 during cycle len+3, busy_o=0 same cycle.
- len=0: no writes, busy_o stays 0, done_o=1 during cycle 1.
- Throughput one element/cycle; no stalls.
- Reset mid-run: pipeline flushed, pending writes dropped, earlier committed writes remain; outputs return to reset values asynchronously.
- Host write in same cycle as start_i is completed before RUN (first engine read at cycle 1 sees it).

## Test plan
- Host writes A[k]=k, B[k]=2k, OP[k]=0 for k=0..7; start base=0 len=8 → RESULT[k]=3k, done_o pulse at cycle 11, busy_o high cycles 1-10.
- OP pattern 0..7 with A=0xF0000001, B=0x00000004 → ADD 0xF0000005, SUB 0xEFFFFFFD, AND 0, OR 0xF0000005, XOR 0xF0000005, SLL 0x00000010, SRL 0x0F000000, SLTU 0.
- base=1020 len=8 (ADDR_WIDTH=10) → RESULT written at 1020..1023 and 0..3, index 4 untouched.
- len=0 → done_o at cycle 1, no RESULT change; len=1024 → all 1024 entries written, done_o at cycle 1027.
- Host write to A during busy → ignored (readback after done shows old value); start_i during RUN → no restart.
- RST low at cycle 5 of an 8-element run → busy_o/done_o=0 immediately; RESULT[0..2] updated, RESULT[3..7] unchanged; new run afterwards completes normally.
